// File: rtl/clock_pkg.sv
// Shared definitions for the clock digit chain and its set-time controller.
package clock_pkg;

  localparam int NDIG_DEFAULT = 6;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_e;

  // Ceiling log2, never below 1 so single-value counters still get a bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-FF synchronizer, stability counter, and a
// one-cycle press pulse on every accepted 0->1 transition.
module btn_debounce
  import clock_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // The sample that would bring the count to DEB_CYCLES flips the level instead.
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Set-time front end: RUN/SET mode FSM, digit selection, increment pulses with
// auto-repeat, and the display blink strobe, all driven from three raw buttons.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int NDIG         = NDIG_DEFAULT,
  parameter int DEB_CYCLES   = 4,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2,
  parameter int BLINK_HALF   = 4,
  localparam int SW          = clog2(NDIG)
) (
  input  logic            clkmain,
  input  logic            clear,
  input  logic            btn_mode,
  input  logic            btn_next,
  input  logic            btn_inc,
  output logic            set_time,
  output logic [NDIG-1:0] slt,
  output logic [SW-1:0]   sel_idx,
  output logic            blink,
  output logic            state_dbg
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = clog2(REP_MAX + 1);
  localparam int BW      = clog2(BLINK_HALF + 1);

  localparam logic [SW-1:0] SEL_MAX    = SW'(NDIG - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic mode_press, next_press, inc_press;
  logic mode_level, next_level, inc_level;
  logic unused_levels;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk(clkmain), .clear(clear), .btn_raw(btn_mode), .level(mode_level), .press(mode_press)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk(clkmain), .clear(clear), .btn_raw(btn_next), .level(next_level), .press(next_press)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk(clkmain), .clear(clear), .btn_raw(btn_inc), .level(inc_level), .press(inc_press)
  );

  assign unused_levels = mode_level ^ next_level;

  state_e          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [NDIG-1:0] slt_q, slt_d;
  logic            blink_q, blink_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
  logic            rep_active_q, rep_active_d;
  logic            rep_rate_q, rep_rate_d;
  logic            rep_fire;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    slt_d        = '0;
    blink_d      = 1'b0;
    blink_cnt_d  = '0;
    rep_cnt_d    = '0;
    rep_active_d = 1'b0;
    rep_rate_d   = 1'b0;
    rep_fire     = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mode_press) begin
          state_d = ST_SET;
          sel_d   = SEL_MAX;
          blink_d = 1'b1;
        end
      end

      ST_SET: begin
        blink_d = blink_q;
        if (blink_cnt_q >= BLINK_LAST) begin
          blink_d = ~blink_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end

        // Repeat engine: first gap is REPEAT_DELAY, later gaps REPEAT_RATE.
        if (rep_active_q && inc_level) begin
          rep_active_d = 1'b1;
          rep_rate_d   = rep_rate_q;
          if (rep_cnt_q >= (rep_rate_q ? RATE_LAST : DELAY_LAST)) begin
            rep_fire   = 1'b1;
            rep_rate_d = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + RW'(1);
          end
        end

        if (mode_press) begin
          state_d      = ST_RUN;
          blink_d      = 1'b0;
          blink_cnt_d  = '0;
          rep_active_d = 1'b0;
          rep_rate_d   = 1'b0;
          rep_cnt_d    = '0;
        end else begin
          if (next_press) begin
            sel_d       = (sel_q == '0) ? SEL_MAX : sel_q - SW'(1);
            blink_d     = 1'b1;
            blink_cnt_d = '0;
          end else if (inc_press) begin
            rep_active_d = 1'b1;
            rep_rate_d   = 1'b0;
            rep_cnt_d    = '0;
            rep_fire     = 1'b1;
          end
          // Pulse follows the selection as it stands after this edge.
          if (rep_fire) begin
            slt_d = NDIG'(1) << sel_d;
          end
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clkmain) begin
    if (clear) begin
      state_q      <= ST_RUN;
      sel_q        <= SEL_MAX;
      slt_q        <= '0;
      blink_q      <= 1'b0;
      blink_cnt_q  <= '0;
      rep_cnt_q    <= '0;
      rep_active_q <= 1'b0;
      rep_rate_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      slt_q        <= slt_d;
      blink_q      <= blink_d;
      blink_cnt_q  <= blink_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      rep_active_q <= rep_active_d;
      rep_rate_q   <= rep_rate_d;
    end
  end

  assign set_time  = (state_q == ST_SET);
  assign slt       = slt_q;
  assign sel_idx   = sel_q;
  assign blink     = blink_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with NDIG=6, DEB_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_RATE=2, BLINK_HALF=4.
module tb_time_set_ctrl;

  logic       clk;
  logic       clear;
  logic       btn_mode, btn_next, btn_inc;
  logic       set_time;
  logic [5:0] slt;
  logic [2:0] sel_idx;
  logic       blink;
  logic       state_dbg;

  int n_cmp;
  int n_bad;
  logic [2:0] exp_sel;
  logic [5:0] exp_slt;

  // Mod-10 digit standing in for one counter of the chain.
  logic [3:0] digit;
  logic       digit_zero;

  time_set_ctrl #(
    .NDIG(6), .DEB_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_RATE(2), .BLINK_HALF(4)
  ) dut (
    .clkmain(clk), .clear(clear), .btn_mode(btn_mode), .btn_next(btn_next),
    .btn_inc(btn_inc), .set_time(set_time), .slt(slt), .sel_idx(sel_idx),
    .blink(blink), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (digit_zero) digit <= 4'd0;
    else if (set_time && slt[0]) digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
    tick();
    clear = 1'b0;
    n_cmp++; if (set_time !== 1'b0) begin n_bad++; $display("FAIL reset_set_time: got %b want 0", set_time); end
    n_cmp++; if (slt !== 6'b0) begin n_bad++; $display("FAIL reset_slt: got %b want 000000", slt); end
    n_cmp++; if (sel_idx !== 3'd5) begin n_bad++; $display("FAIL reset_sel_idx: got %0d want 5", sel_idx); end
    n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL reset_blink: got %b want 0", blink); end
    n_cmp++; if (state_dbg !== 1'b0) begin n_bad++; $display("FAIL reset_state: got %b want 0", state_dbg); end
  endtask

  task automatic test_debounce();
    btn_mode = 1'b1;
    repeat (3) tick();
    btn_mode = 1'b0;
    repeat (10) tick();
    n_cmp++; if (set_time !== 1'b0) begin n_bad++; $display("FAIL deb_glitch: got set_time %b want 0", set_time); end
    btn_mode = 1'b1;
    repeat (6) tick();
    n_cmp++; if (set_time !== 1'b0) begin n_bad++; $display("FAIL deb_early: got set_time %b want 0 at E+5", set_time); end
    tick();
    n_cmp++; if (set_time !== 1'b1) begin n_bad++; $display("FAIL deb_enter: got set_time %b want 1 at E+6", set_time); end
    n_cmp++; if (blink !== 1'b1) begin n_bad++; $display("FAIL deb_blink_entry: got %b want 1", blink); end
    n_cmp++; if (sel_idx !== 3'd5) begin n_bad++; $display("FAIL deb_sel_entry: got %0d want 5", sel_idx); end
    n_cmp++; if (slt !== 6'b0) begin n_bad++; $display("FAIL deb_slt_entry: got %b want 000000", slt); end
    btn_mode = 1'b0;
    repeat (8) tick();
    n_cmp++; if (set_time !== 1'b1) begin n_bad++; $display("FAIL deb_release: got set_time %b want 1", set_time); end
  endtask

  task automatic test_select();
    exp_sel = 3'd5;
    for (int i = 0; i < 9; i++) begin
      btn_next = 1'b1;
      repeat (7) tick();
      exp_sel = (exp_sel == 3'd0) ? 3'd5 : exp_sel - 3'd1;
      n_cmp++; if (sel_idx !== exp_sel) begin n_bad++; $display("FAIL sel_step%0d: got %0d want %0d", i, sel_idx, exp_sel); end
      n_cmp++; if (blink !== 1'b1) begin n_bad++; $display("FAIL sel_blink%0d: got %b want 1", i, blink); end
      n_cmp++; if (slt !== 6'b0) begin n_bad++; $display("FAIL sel_slt%0d: got %b want 000000", i, slt); end
      btn_next = 1'b0;
      repeat (8) tick();
    end
    btn_inc = 1'b1;
    repeat (6) tick();
    n_cmp++; if (slt !== 6'b0) begin n_bad++; $display("FAIL inc_early: got %b want 000000", slt); end
    tick();
    n_cmp++; if (slt !== 6'b000100) begin n_bad++; $display("FAIL inc_pulse: got %b want 000100", slt); end
    btn_inc = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      n_cmp++; if (slt !== 6'b0) begin n_bad++; $display("FAIL inc_after%0d: got %b want 000000", k, slt); end
    end
  endtask

  task automatic test_blink();
    btn_next = 1'b1;
    repeat (7) tick();
    exp_sel = (exp_sel == 3'd0) ? 3'd5 : exp_sel - 3'd1;
    n_cmp++; if (blink !== 1'b1) begin n_bad++; $display("FAIL blink_n0: got %b want 1", blink); end
    repeat (3) tick();
    n_cmp++; if (blink !== 1'b1) begin n_bad++; $display("FAIL blink_n3: got %b want 1", blink); end
    tick();
    n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL blink_n4: got %b want 0", blink); end
    repeat (3) tick();
    n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL blink_n7: got %b want 0", blink); end
    tick();
    n_cmp++; if (blink !== 1'b1) begin n_bad++; $display("FAIL blink_n8: got %b want 1", blink); end
    btn_next = 1'b0;
    repeat (8) tick();
    n_cmp++; if (sel_idx !== exp_sel) begin n_bad++; $display("FAIL blink_sel: got %0d want %0d", sel_idx, exp_sel); end
  endtask

  task automatic test_auto_repeat();
    logic [5:0] one_hot;
    one_hot = 6'd1 << exp_sel;
    btn_inc = 1'b1;
    repeat (7) tick();
    for (int t = 0; t <= 35; t++) begin
      if (t > 0) tick();
      // Pulses at 0, 8, 10, ... up to the edge where the release is accepted (offset 26).
      exp_slt = (t == 0 || (t >= 8 && t <= 26 && (t % 2) == 0)) ? one_hot : 6'b0;
      n_cmp++; if (slt !== exp_slt) begin n_bad++; $display("FAIL repeat_t%0d: got %b want %b", t, slt, exp_slt); end
      if (t == 20) btn_inc = 1'b0;
    end
    repeat (5) tick();
  endtask

  task automatic test_priority();
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_cmp++; if (slt !== 6'b0) begin n_bad++; $display("FAIL prio_slt%0d: got %b want 000000", k, slt); end
    end
    n_cmp++; if (set_time !== 1'b0) begin n_bad++; $display("FAIL prio_exit: got set_time %b want 0", set_time); end
    n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL prio_blink: got %b want 0", blink); end
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (8) tick();
    btn_inc = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++; if (slt !== 6'b0) begin n_bad++; $display("FAIL run_inc_slt%0d: got %b want 000000", k, slt); end
    end
    btn_inc = 1'b0;
    repeat (8) tick();
    n_cmp++; if (set_time !== 1'b0) begin n_bad++; $display("FAIL run_inc_state: got set_time %b want 0", set_time); end
  endtask

  task automatic test_clear_mid_repeat();
    btn_mode = 1'b1;
    repeat (7) tick();
    n_cmp++; if (set_time !== 1'b1) begin n_bad++; $display("FAIL clr_enter: got set_time %b want 1", set_time); end
    btn_mode = 1'b0;
    repeat (8) tick();
    btn_inc = 1'b1;
    repeat (7) tick();
    n_cmp++; if (slt !== 6'b100000) begin n_bad++; $display("FAIL clr_first: got %b want 100000", slt); end
    repeat (8) tick();
    n_cmp++; if (slt !== 6'b100000) begin n_bad++; $display("FAIL clr_repeat: got %b want 100000", slt); end
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++; if (set_time !== 1'b0) begin n_bad++; $display("FAIL clr_set_time: got %b want 0", set_time); end
    n_cmp++; if (slt !== 6'b0) begin n_bad++; $display("FAIL clr_slt: got %b want 000000", slt); end
    n_cmp++; if (sel_idx !== 3'd5) begin n_bad++; $display("FAIL clr_sel_idx: got %0d want 5", sel_idx); end
    n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL clr_blink: got %b want 0", blink); end
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_cmp++; if (slt !== 6'b0 || set_time !== 1'b0) begin
        n_bad++; $display("FAIL clr_hold%0d: got slt %b set_time %b want 000000 0", k, slt, set_time);
      end
    end
    btn_inc = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_integration();
    logic [3:0] exp_digit;
    digit_zero = 1'b1;
    tick();
    digit_zero = 1'b0;
    exp_digit = 4'd0;
    btn_mode = 1'b1;
    repeat (7) tick();
    btn_mode = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 5; i++) begin
      btn_next = 1'b1;
      repeat (7) tick();
      btn_next = 1'b0;
      repeat (8) tick();
    end
    n_cmp++; if (sel_idx !== 3'd0) begin n_bad++; $display("FAIL int_sel: got %0d want 0", sel_idx); end
    for (int i = 0; i < 12; i++) begin
      btn_inc = 1'b1;
      repeat (7) tick();
      btn_inc = 1'b0;
      repeat (8) tick();
      exp_digit = (exp_digit == 4'd9) ? 4'd0 : exp_digit + 4'd1;
      n_cmp++; if (digit !== exp_digit) begin n_bad++; $display("FAIL int_digit%0d: got %0d want %0d", i, digit, exp_digit); end
    end
    repeat (20) tick();
    n_cmp++; if (digit !== 4'd2) begin n_bad++; $display("FAIL int_hold: got %0d want 2", digit); end
    n_cmp++; if (set_time !== 1'b1) begin n_bad++; $display("FAIL int_state: got set_time %b want 1", set_time); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear = 1'b1;
    btn_mode = 1'b0;
    btn_next = 1'b0;
    btn_inc = 1'b0;
    digit_zero = 1'b1;
    test_reset();
    test_debounce();
    test_select();
    test_blink();
    test_auto_repeat();
    test_priority();
    test_clear_mid_repeat();
    test_integration();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
